serial_frame_arbiter: RTL

- Shares one 5-bit serial frame sequencer (start bit, D[0..4] LSB first, stop bit) between N requesters.
- Arbitrates round-robin and latches the winner's word.
- Drives the sequencer's start and data inputs with exact frame timing, so the sequencer is never restarted mid-frame.
- Sits between requester logic and the sequencer; the sequencer's reset is tied to the same system reset.

---
 rtl/serial_frame_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_arbiter.sv
// serial_frame_arbiter: round-robin sharing of one 5-bit serial frame sequencer
// between N requesters, with exact start/data timing and optional idle gap.
// Optional sequencer output checking is enabled with SERIAL_FRAME_CHECK_EN.
module serial_frame_arbiter #(
   parameter int unsigned N          = 4,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [5*N-1:0]   req_data,
`ifdef SERIAL_FRAME_CHECK_EN
   input  logic             seq_y,
   input  logic             seq_mesgul,
   output logic             frame_err,
`endif
   output logic [N-1:0]     ack,
   output logic [2:0]       grant_id,
   output logic             seq_baslat,
   output logic [4:0]       seq_d,
   output logic             busy
);

   localparam int unsigned DW  = 5;
   localparam int unsigned IDW = 3;
   localparam int unsigned CW  = 4;
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FRAME = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic           seq_baslat_q, seq_baslat_d;
   logic [DW-1:0]  seq_d_q, seq_d_d;
   logic           busy_q, busy_d;

   logic           any_req;
   logic [IDW-1:0] win_id;
   logic [IW-1:0]  arb_idx;
   logic [DW-1:0]  win_word;
   logic           start;

   // Round-robin search starting just after the last winner, with wrap
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      arb_idx = '0;
      for (int i = 1; i <= int'(N); i++) begin
         arb_idx = IW'((int'(rr_ptr_q) + i) % int'(N));
         if (!any_req && req[arb_idx]) begin
            any_req = 1'b1;
            win_id  = IDW'(arb_idx);
         end
      end
   end

   // Winner's word mux
   always_comb begin
      win_word = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (win_id == IDW'(i)) win_word = req_data[DW*i +: DW];
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      ack_d        = '0;
      grant_id_d   = grant_id_q;
      seq_baslat_d = 1'b0;
      seq_d_d      = seq_d_q;
      busy_d       = busy_q;
      start        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any_req) start = 1'b1;
         end
         S_FRAME: begin
            if (cnt_q == CW'(7)) begin
               if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end else if (any_req) begin
                  start = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               if (any_req) begin
                  start = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Frame start: latch winner and pulse start/ack for one cycle
      if (start) begin
         state_d      = S_FRAME;
         cnt_d        = '0;
         seq_d_d      = win_word;
         ack_d        = N'(1) << win_id;
         grant_id_d   = win_id;
         rr_ptr_d     = win_id;
         seq_baslat_d = 1'b1;
         busy_d       = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rr_ptr_q     <= IDW'(N - 1);
         ack_q        <= '0;
         grant_id_q   <= '0;
         seq_baslat_q <= 1'b0;
         seq_d_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         ack_q        <= ack_d;
         grant_id_q   <= grant_id_d;
         seq_baslat_q <= seq_baslat_d;
         seq_d_q      <= seq_d_d;
         busy_q       <= busy_d;
      end
   end

   assign ack        = ack_q;
   assign grant_id   = grant_id_q;
   assign seq_baslat = seq_baslat_q;
   assign seq_d      = seq_d_q;
   assign busy       = busy_q;

`ifdef SERIAL_FRAME_CHECK_EN
   logic frame_err_q, frame_err_d;
   logic exp_y, exp_m, chk;

   // Compare sequencer outputs against the expected frame shape
   always_comb begin
      frame_err_d = frame_err_q;
      exp_y       = 1'b0;
      exp_m       = 1'b0;
      chk         = 1'b0;
      if (state_q == S_FRAME) begin
         case (cnt_q)
            CW'(1): begin exp_y = 1'b0;       exp_m = 1'b0; chk = 1'b1; end
            CW'(2): begin exp_y = seq_d_q[0]; exp_m = 1'b1; chk = 1'b1; end
            CW'(3): begin exp_y = seq_d_q[1]; exp_m = 1'b1; chk = 1'b1; end
            CW'(4): begin exp_y = seq_d_q[2]; exp_m = 1'b1; chk = 1'b1; end
            CW'(5): begin exp_y = seq_d_q[3]; exp_m = 1'b1; chk = 1'b1; end
            CW'(6): begin exp_y = seq_d_q[4]; exp_m = 1'b1; chk = 1'b1; end
            CW'(7): begin exp_y = 1'b1;       exp_m = 1'b0; chk = 1'b1; end
            default: chk = 1'b0;
         endcase
      end
      if (chk && ((seq_y != exp_y) || (seq_mesgul != exp_m))) frame_err_d = 1'b1;
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) frame_err_q <= 1'b0;
      else        frame_err_q <= frame_err_d;
   end

   assign frame_err = frame_err_q;
`endif

endmodule
